rr_grant_arbiter4: RTL and testbench



---
 rtl/rr_grant_arbiter4_pkg.sv | 14 +
 rtl/rr_grant_arbiter4_pick4.sv | 28 ++
 rtl/rr_grant_arbiter4.sv | 84 ++++++++
 tb/tb_rr_grant_arbiter4.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter4_pkg.sv
// Shared constants and state encoding for the 4-way round-robin grant arbiter.
package rr_grant_arbiter4_pkg;

  localparam int N                = 4;
  localparam int IDX_W            = 2;
  localparam int MAX_HOLD_DEFAULT = 8;
  localparam int CNT_W_DEFAULT    = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_grant_arbiter4_pick4.sv
// Combinational round-robin pick: rotate req so ptr is at bit 0, take the lowest
// set bit, then add ptr back to recover the absolute requester index.
module rr_pick4
  import rr_grant_arbiter4_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_any
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] enc;

  assign rot = N'({req, req} >> ptr);

  // Descending scan so the lowest set bit of the rotated vector wins.
  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
  end

  assign pick_idx = enc + ptr;
  assign pick_any = |req;

endmodule

// File: rtl/rr_grant_arbiter4.sv
// Registered 4-requester round-robin arbiter; tenure ends on done, owner drop,
// or after MAX_HOLD cycles (flagged by a one-cycle timeout pulse).
module rr_grant_arbiter4
  import rr_grant_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t           state_q;
  logic [N-1:0]     gnt_q;
  logic [IDX_W-1:0] idx_q, ptr_q, ptr_d, pick_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, timeout_q;
  logic             pick_any, owner_end, hold_limit;

  rr_pick4 u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  assign ptr_d      = idx_q + IDX_W'(1);
  assign cnt_d      = cnt_q + CNT_W'(1);
  assign owner_end  = !req[idx_q] || done;
  assign hold_limit = (cnt_q == CNT_W'(MAX_HOLD));

  // Every release path returns to IDLE, which forces the one dead cycle between tenures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timeout_q <= 1'b0;
          if (pick_any) begin
            gnt_q   <= N'(1) << pick_idx;
            idx_q   <= pick_idx;
            valid_q <= 1'b1;
            cnt_q   <= CNT_W'(1);
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (owner_end || hold_limit) begin
            timeout_q <= !owner_end;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= ptr_d;
            state_q   <= ST_IDLE;
          end else begin
            timeout_q <= 1'b0;
            cnt_q     <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter4.sv
// Directed self-checking bench for rr_grant_arbiter4 with hand-computed expectations.
module tb_rr_grant_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int errorCount = 0;
  int checkCount = 0;

  rr_grant_arbiter4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at a falling edge; the next rising edge samples them and we
  // come back to the following falling edge to observe the result.
  task automatic applyStimulus(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expGnt,
                             input logic [1:0] expIdx, input logic expValid,
                             input logic expTimeout);
    checkCount++;
    assert (gnt === expGnt) else begin
      errorCount++;
      $error("[TB] FAIL %s gnt observed=%b expected=%b", tag, gnt, expGnt);
    end
    checkCount++;
    assert (gnt_idx === expIdx) else begin
      errorCount++;
      $error("[TB] FAIL %s gnt_idx observed=%b expected=%b", tag, gnt_idx, expIdx);
    end
    checkCount++;
    assert (gnt_valid === expValid) else begin
      errorCount++;
      $error("[TB] FAIL %s gnt_valid observed=%b expected=%b", tag, gnt_valid, expValid);
    end
    checkCount++;
    assert (timeout === expTimeout) else begin
      errorCount++;
      $error("[TB] FAIL %s timeout observed=%b expected=%b", tag, timeout, expTimeout);
    end
  endtask

  initial begin
    logic [1:0] expIdx;
    rst_n = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;

    // Reset and idle
    #2 rst_n = 1'b0;
    #1 checkOutput("reset", 4'b0000, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0000, 1'b0);
      checkOutput("idle", 4'b0000, 2'b00, 1'b0, 1'b0);
    end

    // Single requester, done in third grant cycle, re-grant after one dead cycle
    $display("[TB] single requester");
    applyStimulus(4'b0100, 1'b0);
    checkOutput("single_g1", 4'b0100, 2'b10, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("single_g2", 4'b0100, 2'b10, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("single_g3", 4'b0100, 2'b10, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("single_rel", 4'b0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("single_regrant", 4'b0100, 2'b10, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("single_drop", 4'b0000, 2'b00, 1'b0, 1'b0);

    // Restart from ptr=0 for rotation
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin rotation with all four requesting
    $display("[TB] rotation");
    for (int k = 0; k < 8; k++) begin
      expIdx = 2'(k);
      applyStimulus(4'b1111, 1'b0);
      checkOutput("rot_g1", 4'b0001 << expIdx, expIdx, 1'b1, 1'b0);
      applyStimulus(4'b1111, 1'b0);
      checkOutput("rot_g2", 4'b0001 << expIdx, expIdx, 1'b1, 1'b0);
      applyStimulus(4'b1111, 1'b1);
      checkOutput("rot_gap", 4'b0000, 2'b00, 1'b0, 1'b0);
    end

    // Pointer wrapped to 0 after owner 3: 1010 must pick bit 1, then bit 3
    $display("[TB] wrap and skip");
    applyStimulus(4'b1010, 1'b0);
    checkOutput("wrap_pick1", 4'b0010, 2'b01, 1'b1, 1'b0);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("wrap_rel", 4'b0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(4'b1010, 1'b0);
    checkOutput("skip_pick3", 4'b1000, 2'b11, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("skip_drop", 4'b0000, 2'b00, 1'b0, 1'b0);

    // Timeout after exactly 8 grant cycles
    $display("[TB] timeout");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0001, 1'b0);
      checkOutput("to_hold", 4'b0001, 2'b00, 1'b1, 1'b0);
    end
    applyStimulus(4'b0001, 1'b0);
    checkOutput("to_pulse", 4'b0000, 2'b00, 1'b0, 1'b1);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("to_regrant", 4'b0001, 2'b00, 1'b1, 1'b0);

    // done coinciding with the hold limit wins: release without timeout
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'b0001, 1'b0);
      checkOutput("lim_hold", 4'b0001, 2'b00, 1'b1, 1'b0);
    end
    applyStimulus(4'b0001, 1'b1);
    checkOutput("lim_done", 4'b0000, 2'b00, 1'b0, 1'b0);

    // done while idle is ignored
    applyStimulus(4'b0000, 1'b1);
    checkOutput("idle_done", 4'b0000, 2'b00, 1'b0, 1'b0);

    // Async reset mid-tenure (ptr is 1 here, so 1111 grants requester 1)
    $display("[TB] async reset");
    applyStimulus(4'b1111, 1'b0);
    checkOutput("ar_grant", 4'b0010, 2'b01, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("ar_clear", 4'b0000, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ar_held", 4'b0000, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 1'b0);
    checkOutput("ar_restart", 4'b0001, 2'b00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
